// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared state encoding and 2-input truth tables for gate_truth_sequencer
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Bit i is the gate output expected for input vector i.
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_seq_hold_timer.sv
// rtl/gate_seq_hold_timer.sv - settle-time counter with terminal-count flag at HOLD_CYC-1
module gate_seq_hold_timer #(
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TW'(HOLD_CYC - 1));

endmodule

// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - exhaustive truth-table checker for a combinational gate; GATE_SEQ_STOP_ON_FAIL_EN ends a run at the first mismatch
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int                  N_IN     = 2,
  parameter int                  HOLD_CYC = 4,
  parameter logic [2**N_IN-1:0]  EXPECT   = TT_OR2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_seen
);

  state_t          state;
  logic [N_IN-1:0] vec;
  logic            hold_tc;
  logic            mismatch;
  logic            last_vec;
  logic            stop_run;
  logic [N_IN:0]   err_next;

  gate_seq_hold_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != DRIVE) || hold_tc),
    .en    (state == DRIVE),
    .tc    (hold_tc)
  );

  assign mismatch = (gate_y != EXPECT[vec]);
  assign last_vec = &vec;
  assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign stop_run = last_vec || mismatch;
`else
  assign stop_run = last_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      gate_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else begin
      case (state)
        // A start in DONE is a fresh run, identical to one from IDLE.
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            vec       <= '0;
            gate_in   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_vec  <= '0;
            fail_seen <= 1'b0;
          end
        end
        DRIVE: begin
          if (hold_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_next;
            if (!fail_seen) begin
              fail_vec  <= vec;
              fail_seen <= 1'b1;
            end
          end
          if (stop_run) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            state   <= DRIVE;
            vec     <= vec + 1'b1;
            gate_in <= vec + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
